// File: rtl/rede_io_host_pkg.sv
// Shared defaults and helpers for the rede host-side I/O block.
package rede_io_host_pkg;

  localparam int unsigned NUBITS_DEF = 31;
  localparam int unsigned NUIOIN_DEF = 4;
  localparam int unsigned NUIOOU_DEF = 4;
  localparam int unsigned IDEPTH_DEF = 8;
  localparam int unsigned ODEPTH_DEF = 16;

  // Index width for n channels; a single channel still gets a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rede_io_host_fifo.sv
// Synchronous FIFO with a zero-latency head output; head reads 0 when empty.
module rede_io_host_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rede_io_host.sv
// Host-side I/O partner of rede: per-channel input FIFOs feed io_in, a tagged output FIFO captures io_out.
module rede_io_host
  import rede_io_host_pkg::*;
#(
  parameter int unsigned NUBITS = NUBITS_DEF,
  parameter int unsigned NUIOIN = NUIOIN_DEF,
  parameter int unsigned NUIOOU = NUIOOU_DEF,
  parameter int unsigned IDEPTH = IDEPTH_DEF,
  parameter int unsigned ODEPTH = ODEPTH_DEF,
  localparam int unsigned ICW   = idx_w(NUIOIN),
  localparam int unsigned OCW   = idx_w(NUIOOU)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic [ICW-1:0]    s_chan,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [NUBITS-1:0] io_in,
  input  logic [NUIOIN-1:0] req_in,
  input  logic [NUBITS-1:0] io_out,
  input  logic [NUIOOU-1:0] out_en,
  output logic [NUBITS-1:0] m_data,
  output logic [OCW-1:0]    m_chan,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [NUIOIN-1:0] udf_flag,
  output logic              ovf_flag,
  input  logic              flag_clr
);

  localparam int unsigned OW = NUBITS + OCW;

  logic [NUBITS-1:0] in_head [NUIOIN];
  logic [NUIOIN-1:0] in_full;
  logic [NUIOIN-1:0] in_empty;
  logic [NUIOIN-1:0] in_push;
  logic [NUIOIN-1:0] in_pop;
  logic [NUIOIN-1:0] udf_set;
  logic [ICW-1:0]    req_idx;
  logic              req_any;
  logic [OCW-1:0]    out_idx;
  logic              out_any;
  logic [OW-1:0]     o_head;
  logic              o_full;
  logic              o_empty;

  // Lowest set bit wins on both strobes; extra bits are ignored.
  always_comb begin
    req_any = 1'b0;
    req_idx = '0;
    for (int i = int'(NUIOIN) - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        req_any = 1'b1;
        req_idx = ICW'(i);
      end
    end
  end

  always_comb begin
    out_any = 1'b0;
    out_idx = '0;
    for (int i = int'(NUIOOU) - 1; i >= 0; i--) begin
      if (out_en[i]) begin
        out_any = 1'b1;
        out_idx = OCW'(i);
      end
    end
  end

  // s_chan decode; an out-of-range channel matches nothing and leaves s_ready low.
  always_comb begin
    s_ready = 1'b0;
    in_push = '0;
    in_pop  = '0;
    udf_set = '0;
    for (int k = 0; k < int'(NUIOIN); k++) begin
      if (s_chan == ICW'(k)) begin
        s_ready    = !in_full[k];
        in_push[k] = s_valid && !in_full[k];
      end
      if (req_any && (req_idx == ICW'(k))) begin
        in_pop[k]  = 1'b1;
        udf_set[k] = in_empty[k];
      end
    end
  end

  assign io_in = req_any ? in_head[req_idx] : '0;

  for (genvar g = 0; g < int'(NUIOIN); g++) begin : g_in
    rede_io_host_fifo #(.W(NUBITS), .DEPTH(IDEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push[g]),
      .pop   (in_pop[g]),
      .din   (s_data),
      .head  (in_head[g]),
      .full  (in_full[g]),
      .empty (in_empty[g])
    );
  end

  rede_io_host_fifo #(.W(OW), .DEPTH(ODEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_any),
    .pop   (m_ready),
    .din   ({out_idx, io_out}),
    .head  (o_head),
    .full  (o_full),
    .empty (o_empty)
  );

  assign m_valid          = !o_empty;
  assign {m_chan, m_data} = o_head;

  // Sticky error flags; a clear in the same cycle beats a new set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      udf_flag <= '0;
      ovf_flag <= 1'b0;
    end else if (flag_clr) begin
      udf_flag <= '0;
      ovf_flag <= 1'b0;
    end else begin
      udf_flag <= udf_flag | udf_set;
      ovf_flag <= ovf_flag | (out_any && o_full);
    end
  end

endmodule

// File: tb/tb_rede_io_host.sv
// Self-checking bench for rede_io_host: behavioural queue model plus vector table and corner sequences.
module tb_rede_io_host;

  logic        clk = 1'b0;
  logic        rst;
  logic [30:0] s_data;
  logic [1:0]  s_chan;
  logic        s_valid;
  logic        s_ready;
  logic [30:0] io_in;
  logic [3:0]  req_in;
  logic [30:0] io_out;
  logic [3:0]  out_en;
  logic [30:0] m_data;
  logic [1:0]  m_chan;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  udf_flag;
  logic        ovf_flag;
  logic        flag_clr;

  rede_io_host dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_chan(s_chan), .s_valid(s_valid),
    .s_ready(s_ready), .io_in(io_in), .req_in(req_in), .io_out(io_out), .out_en(out_en),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .udf_flag(udf_flag), .ovf_flag(ovf_flag), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  logic [30:0] mq_in [4][$];
  logic [32:0] mq_out [$];
  logic [3:0]  m_udf;
  logic        m_ovf;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        sv;
    logic [1:0]  sch;
    logic [30:0] sd;
    logic [3:0]  req;
    logic [30:0] ioo;
    logic [3:0]  oen;
    logic        mr;
    logic [30:0] exp_io;
    logic [30:0] exp_md;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int low_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive(input logic sv, input logic [1:0] sch, input logic [30:0] sd,
                       input logic [3:0] req, input logic [30:0] ioo, input logic [3:0] oen,
                       input logic mr, input logic clr);
    s_valid = sv; s_chan = sch; s_data = sd; req_in = req;
    io_out = ioo; out_en = oen; m_ready = mr; flag_clr = clr;
  endtask

  task automatic check_outs();
    int r;
    logic [30:0] e_in;
    logic [32:0] e_o;
    r = low_idx(req_in);
    e_in = '0;
    if (r >= 0 && mq_in[r].size() > 0) e_in = mq_in[r][0];
    e_o = (mq_out.size() > 0) ? mq_out[0] : 33'd0;
    chk("io_in", 64'(io_in), 64'(e_in));
    chk("s_ready", 64'(s_ready), 64'(mq_in[s_chan].size() < 8));
    chk("m_valid", 64'(m_valid), 64'(mq_out.size() > 0));
    chk("m_data", 64'(m_data), 64'(e_o[30:0]));
    chk("m_chan", 64'(m_chan), 64'(e_o[32:31]));
    chk("udf_flag", 64'(udf_flag), 64'(m_udf));
    chk("ovf_flag", 64'(ovf_flag), 64'(m_ovf));
  endtask

  // Reference behaviour of one clock edge, using the inputs held during that cycle.
  task automatic model_edge();
    int r, o;
    logic [3:0] nu;
    logic no, sr, ofull;
    r  = low_idx(req_in);
    o  = low_idx(out_en);
    sr = mq_in[s_chan].size() < 8;
    nu = m_udf;
    no = m_ovf;
    if (r >= 0) begin
      if (mq_in[r].size() > 0) void'(mq_in[r].pop_front());
      else nu[r] = 1'b1;
    end
    if (s_valid && sr) mq_in[s_chan].push_back(s_data);
    ofull = mq_out.size() >= 16;
    if (m_ready && mq_out.size() > 0) void'(mq_out.pop_front());
    if (o >= 0) begin
      if (ofull) no = 1'b1;
      else mq_out.push_back({2'(o), io_out});
    end
    if (flag_clr) begin
      nu = '0;
      no = 1'b0;
    end
    m_udf = nu;
    m_ovf = no;
  endtask

  task automatic settle_and_edge();
    #3;
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input logic sv, input logic [1:0] sch, input logic [30:0] sd,
                     input logic [3:0] req, input logic [30:0] ioo, input logic [3:0] oen,
                     input logic mr, input logic clr);
    drive(sv, sch, sd, req, ioo, oen, mr, clr);
    settle_and_edge();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mq_in[k].delete();
    mq_out.delete();
    m_udf = '0;
    m_ovf = 1'b0;
  endtask

  vec_t tbl [14];

  initial begin
    logic [3:0] rq, oe;
    int sel;

    rst = 1'b0;
    drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_io_in", 64'(io_in), 64'd0);
    rst = 1'b1;

    // Two-word read with underflow on ch2, then a tagged write held with m_ready low.
    tbl[0]  = '{1'b1, 2'd2, 31'h11, 4'b0000, 31'h0, 4'b0000, 1'b0, 31'h0, 31'h0};
    tbl[1]  = '{1'b1, 2'd2, 31'h22, 4'b0000, 31'h0, 4'b0000, 1'b0, 31'h0, 31'h0};
    tbl[2]  = '{1'b0, 2'd2, 31'h0,  4'b0100, 31'h0, 4'b0000, 1'b0, 31'h11, 31'h0};
    tbl[3]  = '{1'b0, 2'd2, 31'h0,  4'b0100, 31'h0, 4'b0000, 1'b0, 31'h22, 31'h0};
    tbl[4]  = '{1'b0, 2'd2, 31'h0,  4'b0100, 31'h0, 4'b0000, 1'b0, 31'h0, 31'h0};
    tbl[5]  = '{1'b0, 2'd0, 31'h0,  4'b0000, 31'h0, 4'b0000, 1'b0, 31'h0, 31'h0};
    tbl[6]  = '{1'b0, 2'd0, 31'h0,  4'b0000, 31'h5A5A, 4'b1000, 1'b0, 31'h0, 31'h0};
    for (int i = 7; i < 12; i++)
      tbl[i] = '{1'b0, 2'd0, 31'h0, 4'b0000, 31'h0, 4'b0000, 1'b0, 31'h0, 31'h5A5A};
    tbl[12] = '{1'b0, 2'd0, 31'h0,  4'b0000, 31'h0, 4'b0000, 1'b1, 31'h0, 31'h5A5A};
    tbl[13] = '{1'b0, 2'd0, 31'h0,  4'b0000, 31'h0, 4'b0000, 1'b0, 31'h0, 31'h0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].sv, tbl[i].sch, tbl[i].sd, tbl[i].req, tbl[i].ioo, tbl[i].oen, tbl[i].mr, 1'b0);
      #3;
      chk("tbl_io_in", 64'(io_in), 64'(tbl[i].exp_io));
      chk("tbl_m_data", 64'(m_data), 64'(tbl[i].exp_md));
      if (i >= 7 && i <= 12) chk("tbl_m_chan", 64'(m_chan), 64'd3);
      if (i == 5) chk("tbl_udf", 64'(udf_flag), 64'b0100);
      #0;
      check_outs();
      @(posedge clk);
      model_edge();
      #1;
    end

    // 17 writes into a 16-deep output FIFO, then drain in order.
    for (int i = 0; i < 17; i++)
      cyc(1'b0, 2'd0, '0, '0, 31'(32'h100 + i), 4'(1 << (i % 4)), 1'b0, 1'b0);
    chk("ovf_set", 64'(ovf_flag), 64'd1);
    chk("ovf_full_valid", 64'(m_valid), 64'd1);
    for (int i = 0; i < 16; i++) begin
      #3;
      chk("drain_order", 64'(m_data), 64'(32'h100 + i));
      drive(1'b0, 2'd0, '0, '0, '0, '0, 1'b1, 1'b0);
      check_outs();
      @(posedge clk);
      model_edge();
      #1;
    end
    chk("drained", 64'(m_valid), 64'd0);

    // Partly fill channels and the output FIFO, then reset mid-traffic.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, 31'(32'hA0 + i), '0, 31'h33, 4'b0010, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, '0, 4'b1000, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 2'd1, '0, 4'b0010, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_s_ready", 64'(s_ready), 64'd1);
    chk("arst_m_valid", 64'(m_valid), 64'd0);
    chk("arst_io_in", 64'(io_in), 64'd0);
    chk("arst_udf", 64'(udf_flag), 64'd0);
    chk("arst_ovf", 64'(ovf_flag), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd1, '0, 4'b0010, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, '0, '0, '0, '0, 1'b0, 1'b1);

    // Fill ch0, refuse a push on full even with a same-cycle read.
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'd0, 31'(32'hC0 + i), '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 31'h7F, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, 2'd1, '0, '0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 31'h77, 4'b0001, '0, '0, 1'b0, 1'b0);
    #3;
    chk("full_rd_ready", 64'(s_ready), 64'd0);
    chk("full_rd_io", 64'(io_in), 64'hC0);
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'd0, '0, 4'b0001, '0, '0, 1'b0, 1'b0);
    chk("ch0_udf", 64'(udf_flag), 64'd1);

    // Clear wins over a same-cycle underflow.
    cyc(1'b0, 2'd0, '0, 4'b0100, '0, '0, 1'b0, 1'b1);
    chk("clr_wins", 64'(udf_flag), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      rq = (sel < 4) ? 4'(1 << sel) : ((sel == 7) ? 4'($urandom) : 4'd0);
      sel = $urandom_range(0, 7);
      oe = (sel < 3) ? 4'(1 << $urandom_range(0, 3)) : ((sel == 7) ? 4'($urandom) : 4'd0);
      cyc(1'($urandom), 2'($urandom), 31'($urandom), rq, 31'($urandom), oe,
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
